// File: rtl/cond_pkg.sv
// Shared types for the conditional-execution unit.
//   cond_e      : ARM condition codes, EQ..AL plus NV (never)
//   flags_t     : stored NZCV flags, packed {n,z,c,v}
//   it_state_e  : IT sequencer states
//   invert_cond : flips the sense of a condition (EQ<->NE, CS<->CC, ...)
package cond_pkg;

  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } it_state_e;

  localparam logic [3:0] AL_CODE = 4'b1110;

  // Condition codes come in complementary pairs differing only in bit 0.
  function automatic logic [3:0] invert_cond(input logic [3:0] c);
    return {c[3:1], ~c[0]};
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Pure combinational condition check of a 4-bit ARM condition code
// against a set of NZCV flags.
//   cond      : condition code
//   flags     : flags to test against
//   cond_ex_c : 1 when the condition holds (NV and unknown codes give 0)
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       cond_ex_c
);

  logic ge;

  assign ge = ~(flags.n ^ flags.v);

  // Decode the condition code
  always_comb begin
    cond_ex_c = 1'b0;
    case (cond_e'(cond))
      EQ:      cond_ex_c = flags.z;
      NE:      cond_ex_c = ~flags.z;
      CS:      cond_ex_c = flags.c;
      CC:      cond_ex_c = ~flags.c;
      MI:      cond_ex_c = flags.n;
      PL:      cond_ex_c = ~flags.n;
      VS:      cond_ex_c = flags.v;
      VC:      cond_ex_c = ~flags.v;
      HI:      cond_ex_c = flags.c & ~flags.z;
      LS:      cond_ex_c = ~flags.c | flags.z;
      GE:      cond_ex_c = ge;
      LT:      cond_ex_c = ~ge;
      GT:      cond_ex_c = ~flags.z & ge;
      LE:      cond_ex_c = flags.z | ~ge;
      AL:      cond_ex_c = 1'b1;
      default: cond_ex_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_it_unit.sv
// Conditional-execution unit with banked NZCV flags and an If-Then sequencer.
// Gates the decoder's PCS/RegW/MemW requests with the effective condition.
//   clk, reset                : clock, async active-low reset
//   valid_i                   : real instruction this cycle (0 = bubble)
//   ctx_sel                   : flag bank in use
//   Cond, ALUFlags, FlagW     : condition field, ALU flags, flag write mask
//   PCS, RegW, MemW           : raw write requests
//   it_start/cond/len/te      : IT instruction and its block description
//   PCSrc, RegWrite, MemWrite : gated write enables (combinational)
//   CondEx, Flags             : effective condition result, flags of ctx_sel
//   it_active, it_remain      : IT block in progress, slots left
//   it_err                    : one-cycle pulse on rejected/aborted IT
module cond_it_unit
  import cond_pkg::*;
#(
  parameter  int unsigned MAX_IT  = 4,
  parameter  int unsigned NUM_CTX = 2,
  localparam int unsigned CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
  localparam int unsigned LEN_W   = $clog2(MAX_IT + 1),
  localparam int unsigned IDX_W   = (MAX_IT > 1) ? $clog2(MAX_IT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [CTX_W-1:0]  ctx_sel,
  input  logic [3:0]        Cond,
  input  logic [3:0]        ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              it_start,
  input  logic [3:0]        it_cond,
  input  logic [LEN_W-1:0]  it_len,
  input  logic [MAX_IT-1:0] it_te,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              CondEx,
  output logic [3:0]        Flags,
  output logic              it_active,
  output logic [LEN_W-1:0]  it_remain,
  output logic              it_err
);

  it_state_e         state_q, state_d;
  flags_t            bank_q [NUM_CTX];
  flags_t            cur_flags;
  logic [3:0]        it_cond_q, it_cond_d;
  logic [MAX_IT-1:0] it_te_q, it_te_d;
  logic [CTX_W-1:0]  ctx_q, ctx_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  remain_d;
  logic              err_d;
  logic [MAX_IT-1:0] len_mask;
  logic [3:0]        eff_cond;
  logic              cond_ex;
  logic              req_ok;
  logic              kill;
  logic              pass;

  // Flags of the selected bank; an out-of-range selector reads as zero
  always_comb begin
    cur_flags = '0;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (ctx_sel == CTX_W'(i)) cur_flags = bank_q[i];
    end
  end

  assign Flags = cur_flags;

  // Slots covered by the requested IT length
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_IT; i++) begin
      len_mask[i] = (LEN_W'(i) < it_len);
    end
  end

  // An AL block may not contain any else slot; NV never predicates
  assign req_ok = (it_len != '0) && (it_len <= LEN_W'(MAX_IT)) && it_te[0] &&
                  !((it_cond == AL_CODE) && ((it_te & len_mask) != len_mask)) &&
                  (it_cond != 4'b1111);

  assign eff_cond = (state_q == S_ACTIVE)
                  ? (it_te_q[idx_q] ? it_cond_q : invert_cond(it_cond_q))
                  : Cond;

  cond_eval u_cond_eval (
    .cond      (eff_cond),
    .flags     (cur_flags),
    .cond_ex_c (cond_ex)
  );

  assign CondEx = cond_ex;

  // IT sequencer next state, slot bookkeeping and write-enable gating
  always_comb begin
    state_d   = state_q;
    it_cond_d = it_cond_q;
    it_te_d   = it_te_q;
    ctx_d     = ctx_q;
    idx_d     = idx_q;
    remain_d  = it_remain;
    err_d     = 1'b0;
    kill      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i && it_start) begin
          kill = 1'b1;
          if (req_ok) begin
            state_d   = S_ACTIVE;
            it_cond_d = it_cond;
            it_te_d   = it_te;
            ctx_d     = ctx_sel;
            idx_d     = '0;
            remain_d  = it_len;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (valid_i) begin
          if (ctx_sel != ctx_q || it_start) begin
            // Context switch or nested IT: drop the block, suppress this slot
            kill     = 1'b1;
            err_d    = 1'b1;
            state_d  = S_IDLE;
            idx_d    = '0;
            remain_d = '0;
          end else if (PCS && cond_ex) begin
            // Taken branch leaves the block; only legal on the final slot
            err_d    = (it_remain != LEN_W'(1));
            state_d  = S_IDLE;
            idx_d    = '0;
            remain_d = '0;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            remain_d = it_remain - LEN_W'(1);
            if (it_remain == LEN_W'(1)) begin
              state_d = S_IDLE;
              idx_d   = '0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    pass     = valid_i & cond_ex & ~kill;
    PCSrc    = PCS  & pass;
    RegWrite = RegW & pass;
    MemWrite = MemW & pass;
  end

  // Sequencer state and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      it_cond_q <= '0;
      it_te_q   <= '0;
      ctx_q     <= '0;
      idx_q     <= '0;
      it_remain <= '0;
      it_err    <= 1'b0;
      it_active <= 1'b0;
    end else begin
      state_q   <= state_d;
      it_cond_q <= it_cond_d;
      it_te_q   <= it_te_d;
      ctx_q     <= ctx_d;
      idx_q     <= idx_d;
      it_remain <= remain_d;
      it_err    <= err_d;
      it_active <= (state_d == S_ACTIVE);
    end
  end

  // Flag banks: only the selected bank updates, and only on a passing instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CTX; i++) bank_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (pass && ctx_sel == CTX_W'(i)) begin
          if (FlagW[1]) {bank_q[i].n, bank_q[i].z} <= ALUFlags[3:2];
          if (FlagW[0]) {bank_q[i].c, bank_q[i].v} <= ALUFlags[1:0];
        end
      end
    end
  end

endmodule
